// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl
//   Mode and time-setting controller for the digital clock. In RUN it passes the 1 Hz tick to
//   the seconds counter. In SET_HOUR and SET_MIN it pauses timekeeping. INC presses, and
//   auto-repeat while INC is held, become single-cycle increment pulses. It also drives blink
//   flags for the field being set.
// Ports
//   ctrl_clock       in   system clock, rising edge
//   ctrl_reset       in   asynchronous active-high reset
//   ctrl_tick        in   1-cycle 1 Hz enable pulse
//   ctrl_btn_mode    in   debounced MODE level (1 = pressed)
//   ctrl_btn_inc     in   debounced INC level (1 = pressed)
//   ctrl_sec_en      out  advance seconds (1 cycle)
//   ctrl_sec_clr     out  clear seconds to 00 (1 cycle)
//   ctrl_min_inc     out  increment minutes (1 cycle)
//   ctrl_hour_inc    out  increment hours (1 cycle)
//   ctrl_blink_hour  out  blank hour digits
//   ctrl_blink_min   out  blank minute digits
//   ctrl_mode        out  00 RUN, 01 SET_HOUR, 10 SET_MIN
module clock_mode_ctrl #(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 12_500_000
) (
  input  logic       ctrl_clock,
  input  logic       ctrl_reset,
  input  logic       ctrl_tick,
  input  logic       ctrl_btn_mode,
  input  logic       ctrl_btn_inc,
  output logic       ctrl_sec_en,
  output logic       ctrl_sec_clr,
  output logic       ctrl_min_inc,
  output logic       ctrl_hour_inc,
  output logic       ctrl_blink_hour,
  output logic       ctrl_blink_min,
  output logic [1:0] ctrl_mode
);

  localparam int unsigned CntW = $clog2(REPEAT_DELAY + REPEAT_PERIOD) + 1;
  localparam logic [CntW-1:0] DelayVal  = CntW'(REPEAT_DELAY);
  localparam logic [CntW-1:0] WrapVal   = CntW'(REPEAT_DELAY + REPEAT_PERIOD);
  localparam logic [CntW-1:0] ReloadVal = CntW'(REPEAT_DELAY + 1);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StSetHour = 2'b01,
    StSetMin  = 2'b10
  } state_e;

  state_e          state_q;
  logic            hist_valid_q;
  logic            btn_mode_q;
  logic            btn_inc_q;
  logic [CntW-1:0] cnt_q;
  logic            phase_q;
  logic            sec_en_q;
  logic            sec_clr_q;
  logic            min_inc_q;
  logic            hour_inc_q;

  logic            rise_mode;
  logic            rise_inc;
  logic            repeat_due;
  logic            inc_fire;
  logic [CntW-1:0] cnt_next;

  // hist_valid_q masks the first cycle after reset so a button held through release is no press.
  always_comb begin
    rise_mode  = ctrl_btn_mode & ~btn_mode_q & hist_valid_q;
    rise_inc   = ctrl_btn_inc & ~btn_inc_q & hist_valid_q;
    // Counter value k means k cycles since press; repeats fire at DELAY, then at DELAY+PERIOD,
    // after which it reloads so the next repeat lands PERIOD cycles later.
    repeat_due = ctrl_btn_inc && (cnt_q != '0) && ((cnt_q == DelayVal) || (cnt_q == WrapVal));
    inc_fire   = rise_inc | repeat_due;
    cnt_next   = '0;
    if (rise_inc) begin
      cnt_next = CntW'(1);
    end else if (ctrl_btn_inc && (cnt_q != '0)) begin
      cnt_next = (cnt_q == WrapVal) ? ReloadVal : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge ctrl_clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q      <= StRun;
      hist_valid_q <= 1'b0;
      btn_mode_q   <= 1'b0;
      btn_inc_q    <= 1'b0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      sec_en_q     <= 1'b0;
      sec_clr_q    <= 1'b0;
      min_inc_q    <= 1'b0;
      hour_inc_q   <= 1'b0;
    end else begin
      hist_valid_q <= 1'b1;
      btn_mode_q   <= ctrl_btn_mode;
      btn_inc_q    <= ctrl_btn_inc;
      sec_en_q     <= 1'b0;
      sec_clr_q    <= 1'b0;
      min_inc_q    <= 1'b0;
      hour_inc_q   <= 1'b0;
      unique case (state_q)
        StRun: begin
          sec_en_q <= ctrl_tick;
          cnt_q    <= '0;
          phase_q  <= 1'b0;
          if (rise_mode) begin
            state_q <= StSetHour;
            phase_q <= 1'b1;
          end
        end
        StSetHour: begin
          if (rise_mode) begin
            state_q <= StSetMin;
            phase_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            if (ctrl_tick) phase_q <= ~phase_q;
            hour_inc_q <= inc_fire;
            cnt_q      <= cnt_next;
          end
        end
        StSetMin: begin
          if (rise_mode) begin
            // Leaving SET restarts seconds from 00.
            state_q   <= StRun;
            phase_q   <= 1'b0;
            sec_clr_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            if (ctrl_tick) phase_q <= ~phase_q;
            min_inc_q <= inc_fire;
            cnt_q     <= cnt_next;
          end
        end
        default: begin
          state_q <= StRun;
          cnt_q   <= '0;
          phase_q <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_sec_en     = sec_en_q;
  assign ctrl_sec_clr    = sec_clr_q;
  assign ctrl_min_inc    = min_inc_q;
  assign ctrl_hour_inc   = hour_inc_q;
  assign ctrl_blink_hour = phase_q & (state_q == StSetHour);
  assign ctrl_blink_min  = phase_q & (state_q == StSetMin);
  assign ctrl_mode       = state_q;

endmodule
